// File: rtl/window_spill_fill_engine.sv
// Register-window spill/fill engine: moves one 16-word window between the register file
// and the memory stack on a window trap, then rewrites WIM. Optional stats: WSF_STATS_EN.
module window_spill_fill_engine #(
    parameter int NWIN     = 4,
    parameter int WIN_BITS = 2,
    parameter int NREGS    = 16,
    parameter int ADDR_W   = 32
) (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic                ovf_req_i,
    input  logic                unf_req_i,
    input  logic [WIN_BITS-1:0] cwp_i,
    input  logic [ADDR_W-1:0]   sp_addr_i,
    output logic [WIN_BITS-1:0] rf_win_o,
    output logic [3:0]          rf_idx_o,
    output logic                rf_rd_o,
    input  logic [ADDR_W-1:0]   rf_rdata_i,
    output logic                rf_we_o,
    output logic [ADDR_W-1:0]   rf_wdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [ADDR_W-1:0]   mem_wdata_o,
    input  logic [ADDR_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i,
    output logic [NWIN-1:0]     wim_out_o,
    output logic                wim_we_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                align_err_o,
    output logic [15:0]         spill_cnt_o,
    output logic [15:0]         fill_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_SP_RD, S_SP_MEM, S_FL_MEM, S_FL_WB, S_WIM_UPD, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [WIN_BITS-1:0] cwp_q, cwp_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0]   data_q, data_d;
    logic                spill_q, spill_d;
    logic [NWIN-1:0]     wim_q, wim_d;
    logic                align_q, align_d;

    logic [WIN_BITS-1:0] spill_win, fill_win, wim_win;
    logic [NWIN-1:0]     new_wim;
    logic [ADDR_W-1:0]   word_addr;
    logic                last_word;

    // Window arithmetic wraps naturally in WIN_BITS (NWIN is a power of two).
    assign spill_win = cwp_q + WIN_BITS'(2);
    assign fill_win  = cwp_q - WIN_BITS'(1);
    assign wim_win   = spill_q ? (cwp_q + WIN_BITS'(2)) : (cwp_q - WIN_BITS'(2));
    assign new_wim   = NWIN'(1) << wim_win;
    assign word_addr = sp_q + ADDR_W'({idx_q, 2'b00});
    assign last_word = (idx_q == 4'(NREGS - 1));

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cwp_q   <= '0;
            sp_q    <= '0;
            data_q  <= '0;
            spill_q <= 1'b0;
            wim_q   <= '0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cwp_q   <= cwp_d;
            sp_q    <= sp_d;
            data_q  <= data_d;
            spill_q <= spill_d;
            wim_q   <= wim_d;
            align_q <= align_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cwp_d       = cwp_q;
        sp_d        = sp_q;
        data_d      = data_q;
        spill_d     = spill_q;
        wim_d       = wim_q;
        align_d     = 1'b0;
        rf_win_o    = '0;
        rf_idx_o    = '0;
        rf_rd_o     = 1'b0;
        rf_we_o     = 1'b0;
        rf_wdata_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        wim_we_o    = 1'b0;
        done_o      = 1'b0;
        wim_out_o   = wim_q;
        case (state_q)
            S_IDLE: begin
                if (ovf_req_i || unf_req_i) begin
                    cwp_d   = cwp_i;
                    sp_d    = sp_addr_i;
                    spill_d = ovf_req_i;
                    idx_d   = '0;
                    if (sp_addr_i[1:0] != 2'b00) align_d = 1'b1;
                    else state_d = ovf_req_i ? S_SP_RD : S_FL_MEM;
                end
            end
            S_SP_RD: begin
                rf_rd_o  = 1'b1;
                rf_win_o = spill_win;
                rf_idx_o = idx_q;
                data_d   = rf_rdata_i;
                state_d  = S_SP_MEM;
            end
            S_SP_MEM: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = word_addr;
                mem_wdata_o = data_q;
                if (mem_ack_i) begin
                    if (last_word) state_d = S_WIM_UPD;
                    else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_SP_RD;
                    end
                end
            end
            S_FL_MEM: begin
                mem_req_o  = 1'b1;
                mem_addr_o = word_addr;
                if (mem_ack_i) begin
                    data_d  = mem_rdata_i;
                    state_d = S_FL_WB;
                end
            end
            S_FL_WB: begin
                rf_we_o    = 1'b1;
                rf_win_o   = fill_win;
                rf_idx_o   = idx_q;
                rf_wdata_o = data_q;
                if (last_word) state_d = S_WIM_UPD;
                else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_FL_MEM;
                end
            end
            S_WIM_UPD: begin
                wim_we_o  = 1'b1;
                wim_out_o = new_wim;
                wim_d     = new_wim;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign align_err_o = align_q;

`ifdef WSF_STATS_EN
    logic [15:0] spill_cnt_q, spill_cnt_d, fill_cnt_q, fill_cnt_d;

    always_comb begin
        spill_cnt_d = spill_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        if (state_q == S_DONE) begin
            if (spill_q && spill_cnt_q != 16'hFFFF) spill_cnt_d = spill_cnt_q + 16'd1;
            if (!spill_q && fill_cnt_q != 16'hFFFF) fill_cnt_d = fill_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            spill_cnt_q <= '0;
            fill_cnt_q  <= '0;
        end else begin
            spill_cnt_q <= spill_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
        end
    end

    assign spill_cnt_o = spill_cnt_q;
    assign fill_cnt_o  = fill_cnt_q;
`else
    assign spill_cnt_o = 16'd0;
    assign fill_cnt_o  = 16'd0;
`endif

endmodule

// File: tb/tb_window_spill_fill_engine.sv
// Directed bench for window_spill_fill_engine: RF and memory models, store/load/write logs.
module tb_window_spill_fill_engine;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        ovf = 1'b0, unf = 1'b0;
    logic [1:0]  cwp = 2'd0;
    logic [31:0] sp = 32'd0;
    logic [1:0]  rf_win;
    logic [3:0]  rf_idx;
    logic        rf_rd, rf_we, mem_req, mem_we, mem_ack;
    logic [31:0] rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  wim_out;
    logic        wim_we, busy, done, align_err;
    logic [15:0] spill_cnt, fill_cnt;

    int total = 0;
    int bad   = 0;

    window_spill_fill_engine dut (
        .clk_i(clk), .clr_i(clr), .ovf_req_i(ovf), .unf_req_i(unf), .cwp_i(cwp),
        .sp_addr_i(sp), .rf_win_o(rf_win), .rf_idx_o(rf_idx), .rf_rd_o(rf_rd),
        .rf_rdata_i(rf_rdata), .rf_we_o(rf_we), .rf_wdata_o(rf_wdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .wim_out_o(wim_out), .wim_we_o(wim_we), .busy_o(busy), .done_o(done),
        .align_err_o(align_err), .spill_cnt_o(spill_cnt), .fill_cnt_o(fill_cnt)
    );

    always #5 clk = ~clk;

    // RF model: word encodes its window and index; memory model: address xor a tag.
    assign rf_rdata  = {16'hCAFE, 6'd0, rf_win, 4'd0, rf_idx};
    assign mem_rdata = mem_addr ^ 32'h5A5A0000;

    int         wait_n = 0;
    logic [3:0] wcnt = 4'd0;
    assign mem_ack = mem_req && (wcnt == wait_n[3:0]);

    logic [31:0] st_addr [512];
    logic [31:0] st_data [512];
    logic [1:0]  wr_win  [512];
    logic [3:0]  wr_idx  [512];
    logic [31:0] wr_data [512];
    int          st_n = 0, ld_n = 0, wr_n = 0, stab_err = 0;
    logic        pend = 1'b0;
    logic [64:0] pend_snap = '0;

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 4'd1;
        else wcnt <= 4'd0;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                st_addr[st_n] <= mem_addr;
                st_data[st_n] <= mem_wdata;
                st_n <= st_n + 1;
            end else ld_n <= ld_n + 1;
        end
        if (rf_we) begin
            wr_win[wr_n]  <= rf_win;
            wr_idx[wr_n]  <= rf_idx;
            wr_data[wr_n] <= rf_wdata;
            wr_n <= wr_n + 1;
        end
        // Waiting request must keep address, direction and data unchanged.
        if (pend && mem_req && (pend_snap != {mem_we, mem_addr, mem_wdata}))
            stab_err <= stab_err + 1;
        pend      <= mem_req && !mem_ack;
        pend_snap <= {mem_we, mem_addr, mem_wdata};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Issue a request, return cycle numbers (edge 0 = acceptance) of wim_we and done.
    task automatic run_op(input logic o, input logic u, input logic [1:0] c,
                          input logic [31:0] s, input logic keep_unf,
                          output int wcyc, output int dcyc, output logic [3:0] wv);
        wcyc = -1;
        dcyc = -1;
        wv   = 4'hx;
        @(negedge clk);
        ovf = o; unf = u; cwp = c; sp = s;
        @(posedge clk);
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) begin
                ovf = 1'b0;
                if (!keep_unf) unf = 1'b0;
            end
            if (wim_we) begin
                wcyc = n;
                wv   = wim_out;
            end
            if (done) begin
                dcyc = n;
                break;
            end
        end
        unf = 1'b0;
    endtask

    initial begin
        int wc, dc, base, lbase, wbase, seen;
        logic [3:0] wv;

        // Reset
        repeat (2) @(negedge clk);
        check("reset_ctl", {28'd0, busy, done, wim_we, mem_req}, 32'd0);
        check("reset_wim", {28'd0, wim_out}, 32'd0);
        check("reset_rf", {29'd0, rf_rd, rf_we, align_err}, 32'd0);
        check("reset_cnt", {spill_cnt, fill_cnt}, 32'd0);
        clr = 1'b0;
        @(negedge clk);

        // Spill cwp=1 sp=0x100, zero wait: window 3, WIM 1000
        base = st_n;
        run_op(1'b1, 1'b0, 2'd1, 32'h100, 1'b0, wc, dc, wv);
        check("spill_wimwe_cyc", wc, 33);
        check("spill_done_cyc", dc, 34);
        check("spill_wim", {28'd0, wv}, 32'h8);
        check("spill_nstores", st_n - base, 16);
        for (int i = 0; i < 16; i++) begin
            check("spill_addr", st_addr[base+i], 32'h100 + 4*i);
            check("spill_data", st_data[base+i], 32'hCAFE0300 + i);
        end
        @(negedge clk);
        check("spill_idle", {31'd0, busy}, 32'd0);
        check("spill_wim_hold", {28'd0, wim_out}, 32'h8);

        // Fill wrap cwp=0 sp=0x200: window 3, WIM 0100
        wbase = wr_n;
        run_op(1'b0, 1'b1, 2'd0, 32'h200, 1'b0, wc, dc, wv);
        check("fill_wimwe_cyc", wc, 33);
        check("fill_done_cyc", dc, 34);
        check("fill_wim", {28'd0, wv}, 32'h4);
        check("fill_nwrites", wr_n - wbase, 16);
        for (int i = 0; i < 16; i++) begin
            check("fill_win", {30'd0, wr_win[wbase+i]}, 32'd3);
            check("fill_idx", {28'd0, wr_idx[wbase+i]}, i);
            check("fill_data", wr_data[wbase+i], (32'h200 + 4*i) ^ 32'h5A5A0000);
        end

        // Three wait states per word: spill cwp=2 -> window 0, WIM 0001
        wait_n = 3;
        base = st_n;
        run_op(1'b1, 1'b0, 2'd2, 32'h300, 1'b0, wc, dc, wv);
        check("wait_done_cyc", dc, 82);
        check("wait_wimwe_cyc", wc, 81);
        check("wait_wim", {28'd0, wv}, 32'h1);
        check("wait_stable", stab_err, 0);
        check("wait_data0", st_data[base], 32'hCAFE0000);
        check("wait_addr15", st_addr[base+15], 32'h33C);
        wait_n = 0;

        // ovf and unf together: spill wins, unf held high is ignored while busy
        base = st_n;
        lbase = ld_n;
        run_op(1'b1, 1'b1, 2'd1, 32'h100, 1'b1, wc, dc, wv);
        check("both_done_cyc", dc, 34);
        check("both_nstores", st_n - base, 16);
        check("both_nloads", ld_n - lbase, 0);
        check("both_wim", {28'd0, wv}, 32'h8);
        repeat (2) @(negedge clk);
        check("both_idle", {31'd0, busy}, 32'd0);

        // Clr during word 7 of a spill
        base = st_n;
        @(negedge clk);
        ovf = 1'b1; cwp = 2'd3; sp = 32'h400;
        @(negedge clk);
        ovf = 1'b0;
        for (int n = 0; n < 200 && (st_n - base) < 7; n++) @(negedge clk);
        check("clr_reached_w7", st_n - base, 7);
        clr = 1'b1;
        @(negedge clk);
        check("clr_ctl", {25'd0, busy, mem_req, mem_we, rf_rd, rf_we, wim_we, done}, 32'd0);
        check("clr_addr", mem_addr, 32'd0);
        check("clr_wim", {28'd0, wim_out}, 32'd0);
        clr = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (wim_we || done || busy) seen++;
        end
        check("clr_no_resume", seen, 0);
        check("clr_nstores", st_n - base, 7);

        // Misaligned stack pointer
        base = st_n;
        @(negedge clk);
        ovf = 1'b1; cwp = 2'd1; sp = 32'h102;
        @(negedge clk);
        ovf = 1'b0;
        check("align_pulse", {29'd0, align_err, mem_req, busy}, 32'h4);
        @(negedge clk);
        check("align_clear", {29'd0, align_err, mem_req, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("align_nostore", st_n - base, 0);

        // Two spills and one fill for the statistics counters
        run_op(1'b1, 1'b0, 2'd0, 32'h500, 1'b0, wc, dc, wv);
        check("stat_s1_wim", {28'd0, wv}, 32'h4);
        run_op(1'b1, 1'b0, 2'd1, 32'h600, 1'b0, wc, dc, wv);
        run_op(1'b0, 1'b1, 2'd2, 32'h700, 1'b0, wc, dc, wv);
        check("stat_f_wim", {28'd0, wv}, 32'h1);
        @(negedge clk);
`ifdef WSF_STATS_EN
        check("spill_cnt", {16'd0, spill_cnt}, 32'd2);
        check("fill_cnt", {16'd0, fill_cnt}, 32'd1);
`else
        check("spill_cnt", {16'd0, spill_cnt}, 32'd0);
        check("fill_cnt", {16'd0, fill_cnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
